// File: rtl/ysyx_24070017_wbu.sv
// Write-back stage: one result register feeding the GPR file, with rs1/rs2 bypass and a pending-write scoreboard.
// Latency: a result accepted at edge k drives rf_we in cycle k+1 and is forwarded during that cycle.
// Backpressure: in_ready drops while the stage is full and commit_ready is low; issue_ready drops when a counter saturates.
module ysyx_24070017_wbu #(
    parameter int REG_NUM = 16,
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_wen,
    input  logic [ADDR_W-1:0]       in_rd,
    input  logic [XLEN-1:0]         in_data,
    input  logic [XLEN-1:0]         in_pc,
    input  logic                    commit_ready,
    output logic                    commit_valid,
    output logic [XLEN-1:0]         commit_pc,
    output logic [REG_NUM-1:0]      rf_we,
    output logic [REG_NUM*XLEN-1:0] rf_wdata,
    input  logic [REG_NUM*XLEN-1:0] rf_rdata,
    input  logic [ADDR_W-1:0]       rs1_addr,
    input  logic [ADDR_W-1:0]       rs2_addr,
    output logic [XLEN-1:0]         rs1_data,
    output logic [XLEN-1:0]         rs2_data,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    input  logic                    issue_valid,
    input  logic [ADDR_W-1:0]       issue_rd,
    output logic                    issue_ready,
    output logic                    sb_err
);

    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] rd;
        logic [XLEN-1:0]   dat;
        logic [XLEN-1:0]   pc;
    } stage_t;

    logic                   s_vld;
    stage_t                 s_q;
    logic [REG_NUM-1:0][1:0] cnt_q;
    logic [REG_NUM-1:0][1:0] cnt_nxt;
    logic                   sb_err_q;
    logic                   sb_err_nxt;
    logic                   acc;
    logic                   ret;
    logic                   inc;
    logic                   dec;
    logic                   rs1_hit;
    logic                   rs2_hit;

    assign in_ready = ~s_vld | commit_ready;
    assign acc      = in_valid & in_ready;
    assign ret      = s_vld & commit_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_vld <= 1'b0;
        end else if (acc) begin
            s_vld <= 1'b1;
            s_q   <= '{wen: in_wen, rd: in_rd, dat: in_data, pc: in_pc};
        end else if (ret) begin
            s_vld <= 1'b0;
        end
    end

    assign commit_valid = ret;
    assign commit_pc    = s_q.pc;
    assign rf_wdata     = {REG_NUM{s_q.dat}};

    always_comb begin
        rf_we = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            rf_we[i] = ret & s_q.wen & (s_q.rd == ADDR_W'(i));
        end
    end

    assign issue_ready = (cnt_q[issue_rd] != 2'd3);
    assign inc         = issue_valid & issue_ready & (issue_rd != '0);
    assign dec         = ret & s_q.wen & (s_q.rd != '0);

    // Simultaneous inc/dec on one register cancel, so that case never underflows.
    always_comb begin
        cnt_nxt    = cnt_q;
        sb_err_nxt = sb_err_q;
        cnt_nxt[0] = 2'd0;
        for (int i = 1; i < REG_NUM; i++) begin
            if (inc && (issue_rd == ADDR_W'(i)) && !(dec && (s_q.rd == ADDR_W'(i)))) begin
                cnt_nxt[i] = cnt_q[i] + 2'd1;
            end else if (dec && (s_q.rd == ADDR_W'(i)) && !(inc && (issue_rd == ADDR_W'(i)))) begin
                if (cnt_q[i] == 2'd0) begin
                    sb_err_nxt = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt_q[i] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            sb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_nxt;
            sb_err_q <= sb_err_nxt;
        end
    end

    assign sb_err = sb_err_q;

    // The staged value is final, so it is forwarded regardless of commit_ready.
    assign rs1_hit  = s_vld & s_q.wen & (s_q.rd == rs1_addr) & (rs1_addr != '0);
    assign rs2_hit  = s_vld & s_q.wen & (s_q.rd == rs2_addr) & (rs2_addr != '0);

    assign rs1_data = (rs1_addr == '0) ? '0 :
                      rs1_hit ? s_q.dat : rf_rdata[int'(rs1_addr)*XLEN +: XLEN];
    assign rs2_data = (rs2_addr == '0) ? '0 :
                      rs2_hit ? s_q.dat : rf_rdata[int'(rs2_addr)*XLEN +: XLEN];

    assign rs1_busy = cnt_q[rs1_addr] > (rs1_hit ? 2'd1 : 2'd0);
    assign rs2_busy = cnt_q[rs2_addr] > (rs2_hit ? 2'd1 : 2'd0);

endmodule

// File: tb/tb_ysyx_24070017_wbu.sv
// Bench for the write-back unit: vector table for single writes plus hand sequences for stall, saturation, cancel and underflow.
module tb_ysyx_24070017_wbu;

    localparam int REG_NUM = 16;
    localparam int XLEN    = 32;
    localparam int ADDR_W  = 4;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_wen;
    logic [ADDR_W-1:0]       in_rd;
    logic [XLEN-1:0]         in_data;
    logic [XLEN-1:0]         in_pc;
    logic                    commit_ready;
    logic                    commit_valid;
    logic [XLEN-1:0]         commit_pc;
    logic [REG_NUM-1:0]      rf_we;
    logic [REG_NUM*XLEN-1:0] rf_wdata;
    logic [REG_NUM*XLEN-1:0] rf_rdata;
    logic [ADDR_W-1:0]       rs1_addr;
    logic [ADDR_W-1:0]       rs2_addr;
    logic [XLEN-1:0]         rs1_data;
    logic [XLEN-1:0]         rs2_data;
    logic                    rs1_busy;
    logic                    rs2_busy;
    logic                    issue_valid;
    logic [ADDR_W-1:0]       issue_rd;
    logic                    issue_ready;
    logic                    sb_err;

    ysyx_24070017_wbu #(.REG_NUM(REG_NUM), .XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_rd(in_rd),
        .in_data(in_data), .in_pc(in_pc),
        .commit_ready(commit_ready), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Register file environment; preloaded with 0x100+i so unwritten slots are recognisable.
    logic [XLEN-1:0] rf [REG_NUM];
    logic            tb_init;

    always @(posedge clk) begin
        for (int i = 0; i < REG_NUM; i++) begin
            if (tb_init) rf[i] <= 32'h100 + i;
            else if (rf_we[i]) rf[i] <= rf_wdata[i*XLEN +: XLEN];
        end
    end

    always_comb begin
        rf_rdata = '0;
        for (int i = 1; i < REG_NUM; i++) rf_rdata[i*XLEN +: XLEN] = rf[i];
    end

    typedef struct {
        logic [XLEN-1:0]    pc;
        logic [REG_NUM-1:0] we;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: each retirement must match the oldest expected commit.
    always @(negedge clk) begin
        if (!rst && commit_valid && commit_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL commit_unexpected: got pc %0h expected no commit at %0t", commit_pc, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_pc", commit_pc, e.pc);
                chk("commit_we", rf_we, e.we);
            end
        end
    end

    task automatic drive(input logic wen, input logic [ADDR_W-1:0] rd,
                         input logic [XLEN-1:0] data, input logic [XLEN-1:0] pc, input bit push);
        exp_t e;
        in_valid = 1'b1;
        in_wen   = wen;
        in_rd    = rd;
        in_data  = data;
        in_pc    = pc;
        e.pc     = pc;
        e.we     = (wen && rd != 0) ? (REG_NUM'(1) << rd) : '0;
        if (push) exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic               wen;
        logic [ADDR_W-1:0]  rd;
        logic [XLEN-1:0]    data;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    exp_rs;
        logic [REG_NUM-1:0] exp_we;
    } vec_t;
    vec_t vt[5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 4'd5,  32'hDEADBEEF, 32'h80000000, 32'hDEADBEEF, 16'h0020};
        vt[1] = '{1'b0, 4'd6,  32'h11111111, 32'h80000004, 32'h00000106, 16'h0000};
        vt[2] = '{1'b1, 4'd0,  32'h00001234, 32'h80000008, 32'h00000000, 16'h0000};
        vt[3] = '{1'b1, 4'd15, 32'hCAFEF00D, 32'h8000000C, 32'hCAFEF00D, 16'h8000};
        vt[4] = '{1'b1, 4'd5,  32'h00000055, 32'h80000010, 32'h00000055, 16'h0020};

        rst = 1'b1; tb_init = 1'b1;
        in_valid = 1'b0; in_wen = 1'b0; in_rd = '0; in_data = '0; in_pc = '0;
        commit_ready = 1'b1; rs1_addr = 4'd1; rs2_addr = 4'd0;
        issue_valid = 1'b0; issue_rd = '0;
        step(); step();
        rst = 1'b0; tb_init = 1'b0;
        @(negedge clk);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_rs1_busy", rs1_busy, 0);
        chk("rst_sb_err", sb_err, 0);
        step();

        // Single writes: issue, accept, bypass cycle, register-file cycle.
        for (int v = 0; v < 5; v++) begin
            logic need_iss;
            need_iss = vt[v].wen && (vt[v].rd != 0);
            issue_valid = need_iss; issue_rd = vt[v].rd;
            step();
            issue_valid = 1'b0; rs1_addr = vt[v].rd;
            drive(vt[v].wen, vt[v].rd, vt[v].data, vt[v].pc, 1'b1);
            @(negedge clk);
            chk("vec_in_ready", in_ready, 1);
            chk("vec_busy_pre", rs1_busy, need_iss);
            step();
            in_valid = 1'b0;
            @(negedge clk);
            chk("vec_bypass", rs1_data, vt[v].exp_rs);
            chk("vec_busy_s", rs1_busy, 0);
            chk("vec_rf_we", rf_we, vt[v].exp_we);
            chk("vec_commit", commit_valid, 1);
            step();
            rs2_addr = vt[v].rd;
            @(negedge clk);
            chk("vec_rf_read", rs2_data, vt[v].exp_rs);
            chk("vec_busy_post", rs2_busy, 0);
            chk("vec_idle", commit_valid, 0);
            step();
        end
        chk("x0_sb_err", sb_err, 0);

        // Stall: S holds rd=3 for three cycles, then a single commit.
        issue_valid = 1'b1; issue_rd = 4'd3;
        step();
        issue_valid = 1'b0; commit_ready = 1'b0;
        drive(1'b1, 4'd3, 32'h33333333, 32'h80000100, 1'b1);
        @(negedge clk);
        chk("stall_accept", in_ready, 1);
        step();
        in_valid = 1'b0; rs2_addr = 4'd3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_rf_we", rf_we, 0);
            chk("stall_commit", commit_valid, 0);
            chk("stall_rs2_data", rs2_data, 32'h33333333);
            chk("stall_rs2_busy", rs2_busy, 0);
            step();
        end
        commit_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_we", rf_we, 16'h0008);
        chk("stall_release_cv", commit_valid, 1);
        step();
        @(negedge clk);
        chk("stall_after_cv", commit_valid, 0);
        chk("stall_after_rf", rs2_data, 32'h33333333);
        step();

        // Saturation on rd=7, then three back-to-back retirements.
        issue_rd = 4'd7; rs1_addr = 4'd7;
        for (int c = 0; c < 3; c++) begin
            issue_valid = 1'b1;
            @(negedge clk);
            chk("sat_issue_ready", issue_ready, 1);
            step();
        end
        @(negedge clk);
        chk("sat_full", issue_ready, 0);
        chk("sat_busy", rs1_busy, 1);
        step();
        issue_valid = 1'b0;
        drive(1'b1, 4'd7, 32'h77, 32'h80000200, 1'b1);
        step();
        drive(1'b1, 4'd7, 32'h78, 32'h80000204, 1'b1);
        @(negedge clk);
        chk("sat_busy_cnt3", rs1_busy, 1);
        chk("sat_bypass0", rs1_data, 32'h77);
        chk("sat_b2b_ready", in_ready, 1);
        step();
        drive(1'b1, 4'd7, 32'h79, 32'h80000208, 1'b1);
        @(negedge clk);
        chk("sat_busy_cnt2", rs1_busy, 1);
        chk("sat_bypass1", rs1_data, 32'h78);
        chk("sat_issue_ready2", issue_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("sat_busy_cnt1", rs1_busy, 0);
        chk("sat_bypass2", rs1_data, 32'h79);
        step();
        @(negedge clk);
        chk("sat_busy_cnt0", rs1_busy, 0);
        chk("sat_rf7", rs1_data, 32'h79);
        step();

        // Same-cycle issue and retire of rd=4 leaves the counter at 1.
        issue_valid = 1'b1; issue_rd = 4'd4;
        step();
        issue_valid = 1'b0;
        drive(1'b1, 4'd4, 32'h44, 32'h80000300, 1'b1);
        step();
        in_valid = 1'b0; issue_valid = 1'b1; issue_rd = 4'd4; rs1_addr = 4'd4;
        @(negedge clk);
        chk("cancel_issue_ready", issue_ready, 1);
        chk("cancel_busy_hit", rs1_busy, 0);
        chk("cancel_rf_we", rf_we, 16'h0010);
        step();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("cancel_busy_after", rs1_busy, 1);
        chk("cancel_rf4", rs1_data, 32'h44);
        step();

        // Underflow on rd=9, then reset with a pending result in S.
        rs1_addr = 4'd9;
        drive(1'b1, 4'd9, 32'h99, 32'h80000400, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("uf_pre_err", sb_err, 0);
        chk("uf_rf_we", rf_we, 16'h0200);
        step();
        @(negedge clk);
        chk("uf_err", sb_err, 1);
        chk("uf_busy", rs1_busy, 0);
        step();
        commit_ready = 1'b0;
        drive(1'b1, 4'd10, 32'hAA, 32'h80000404, 1'b0);
        @(negedge clk);
        chk("uf_err_sticky", sb_err, 1);
        step();
        in_valid = 1'b0; rst = 1'b1; rs1_addr = 4'd10;
        @(negedge clk);
        chk("rst_pending_err", sb_err, 1);
        chk("rst_pending_bypass", rs1_data, 32'hAA);
        step();
        rst = 1'b0; commit_ready = 1'b1; rs2_addr = 4'd4;
        @(negedge clk);
        chk("rst2_sb_err", sb_err, 0);
        chk("rst2_commit", commit_valid, 0);
        chk("rst2_in_ready", in_ready, 1);
        chk("rst2_rf_we", rf_we, 0);
        chk("rst2_no_write", rs1_data, 32'h10A);
        chk("rst2_cnt_clear", rs2_busy, 0);
        step();
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
